// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the core-side memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_LOAD  = 1;
  localparam int unsigned REQ_STORE = 2;

  localparam int unsigned MEM_ADDR_W = 64;
  localparam int unsigned BUS_ID_W   = 8;

  typedef logic [MEM_ADDR_W-1:0] memory_address_t;
  typedef logic [BUS_ID_W-1:0]   BusID;

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_picker
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // Scan the NUM_REQ positions following last_grant; the first hit wins.
  always_comb begin
    int unsigned cand;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = 32'(last_grant) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                   = 1'b1;
        grant[cand[IDX_W-1:0]]  = 1'b1;
        idx                     = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between NUM_REQ requesters,
// one outstanding transaction at a time.
// Optional build macro: ARB_PERF_COUNTERS_EN (wait/busy performance counters).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ID_W    = BUS_ID_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*ID_W-1:0]   req_id,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_data,
  output logic [ID_W-1:0]       mem_req_id,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data,
  input  logic [ID_W-1:0]       mem_resp_id,
  output logic                  id_mismatch
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [NUM_REQ*32-1:0] wait_cnt,
  output logic [31:0]           busy_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [IDX_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] cur_grant;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;

  logic [ADDR_W-1:0]  addr_slice [NUM_REQ];
  logic [DATA_W-1:0]  data_slice [NUM_REQ];
  logic [ID_W-1:0]    id_slice   [NUM_REQ];

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .idx        (pick_idx)
  );

  // Unpack the flattened requester buses into per-requester views.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_slice[i] = req_addr[i*ADDR_W +: ADDR_W];
      data_slice[i] = req_data[i*DATA_W +: DATA_W];
      id_slice[i]   = req_id[i*ID_W +: ID_W];
    end
  end

  // Accept is combinational so the grant lands in the same cycle the request is seen;
  // gated by reset so all outputs read 0 while reset is asserted.
  always_comb begin
    req_ready = (reset_n && state == ARB_IDLE) ? pick_grant : '0;
  end

  // Transaction FSM: grant, issue to memory, wait for the tagged response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ARB_IDLE;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      cur_grant     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_id    <= '0;
      resp_valid    <= '0;
      resp_data     <= '0;
      id_mismatch   <= 1'b0;
    end else begin
      resp_valid <= '0;
      unique case (state)
        ARB_IDLE: begin
          if (|pick_grant) begin
            cur_grant     <= pick_grant;
            last_grant    <= pick_idx;
            mem_req_write <= req_write[pick_idx];
            mem_req_addr  <= addr_slice[pick_idx];
            mem_req_data  <= data_slice[pick_idx];
            mem_req_id    <= id_slice[pick_idx];
            mem_req_valid <= 1'b1;
            state         <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_resp_valid) begin
            resp_data  <= mem_resp_data;
            resp_valid <= cur_grant;
            if (mem_resp_id != mem_req_id) id_mismatch <= 1'b1;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_COUNTERS_EN
  // Per-requester saturating wait counters and a busy-cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      busy_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !req_ready[i] && wait_cnt[i*32 +: 32] != '1)
          wait_cnt[i*32 +: 32] <= wait_cnt[i*32 +: 32] + 32'd1;
      end
      if (state != ARB_IDLE) busy_cnt <= busy_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*IW-1:0] req_id;
  logic [N-1:0]    req_ready, resp_valid;
  logic [DW-1:0]   resp_data;
  logic            mem_req_valid, mem_req_ready, mem_req_write;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [IW-1:0]   mem_req_id;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_resp_data;
  logic [IW-1:0]   mem_resp_id;
  logic            id_mismatch;
`ifdef ARB_PERF_COUNTERS_EN
  logic [N*32-1:0] wait_cnt;
  logic [31:0]     busy_cnt;
`endif

  mem_bus_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ID_W    (IW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_id         (req_id),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_id     (mem_req_id),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_id    (mem_resp_id),
    .id_mismatch    (id_mismatch)
`ifdef ARB_PERF_COUNTERS_EN
    ,
    .wait_cnt       (wait_cnt),
    .busy_cnt       (busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Requester-side model: each requester holds one pending request.
  logic          rv [N];
  logic          rw [N];
  logic [AW-1:0] ra [N];
  logic [DW-1:0] rd [N];
  logic [IW-1:0] ri [N];

  int            mlast;
  int            fair_idx;
  logic [N-1:0]  exp_resp;
  logic [DW-1:0] exp_rdata;
  logic          exp_mis;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first pending requester after the last granted one.
  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (mlast + k) % N;
      if (rv[c]) return c;
    end
    return -1;
  endfunction

  task automatic new_req(input int i);
    rv[i] = 1'b1;
    rw[i] = 1'($urandom_range(0, 1));
    ra[i] = {$urandom, $urandom} & ~64'h7;
    rd[i] = {$urandom, $urandom};
    ri[i] = 8'($urandom);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = rv[i];
      req_write[i]           = rw[i];
      req_addr[i*AW +: AW]   = ra[i];
      req_data[i*DW +: DW]   = rd[i];
      req_id[i*IW +: IW]     = ri[i];
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req_ready"}, 64'(req_ready), 64'h0);
    check_val({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
    check_val({tag, "_resp_data"}, resp_data, 64'h0);
    check_val({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'h0);
    check_val({tag, "_mem_req_write"}, 64'(mem_req_write), 64'h0);
    check_val({tag, "_mem_req_addr"}, mem_req_addr, 64'h0);
    check_val({tag, "_mem_req_data"}, mem_req_data, 64'h0);
    check_val({tag, "_mem_req_id"}, 64'(mem_req_id), 64'h0);
    check_val({tag, "_id_mismatch"}, 64'(id_mismatch), 64'h0);
  endtask

  task automatic model_reset();
    mlast    = N - 1;
    fair_idx = 0;
    exp_resp = '0;
    exp_mis  = 1'b0;
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
  endtask

  // One full transaction: grant cycle(s), issue with backpressure, wait for response.
  task automatic run_tx(input bit fair, input int nbp_force, input bit abort, input bit late);
    int            g;
    int            nbp;
    int            nw;
    logic          lw;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    logic [IW-1:0] li;
    g = -1;
    for (int cyc = 0; cyc < 20 && g < 0; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (fair) begin
          if (!rv[i]) new_req(i);
        end else if (!rv[i]) begin
          if ($urandom_range(0, 2) == 0 || (cyc >= 10 && i == 0)) new_req(i);
        end else if (cyc < 10 && $urandom_range(0, 7) == 0) begin
          rv[i] = 1'b0;
        end
      end
      mem_req_ready  = 1'($urandom_range(0, 1));
      mem_resp_valid = (late && cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      mem_resp_id    = 8'($urandom);
      mem_resp_data  = {$urandom, $urandom};
      drive();
      #1;
      check_val("resp_valid", 64'(resp_valid), 64'(exp_resp));
      if (exp_resp != '0) check_val("resp_data", resp_data, exp_rdata);
      exp_resp = '0;
      check_val("id_mismatch", 64'(id_mismatch), 64'(exp_mis));
      check_val("idle_mem_req_valid", 64'(mem_req_valid), 64'h0);
      g = model_pick();
      check_val("grant", 64'(req_ready), 64'(onehot(g)));
      if (late && cyc == 0) check_val("post_reset_grant", 64'(req_ready), 64'h1);
    end
    if (g < 0) return;
    if (fair) begin
      check_val("fair_order", 64'(req_ready), 64'(onehot(fair_idx % N)));
      fair_idx++;
    end
    mlast = g;
    lw = rw[g]; la = ra[g]; ld = rd[g]; li = ri[g];

    nbp = (nbp_force >= 0) ? nbp_force : $urandom_range(0, 3);
    for (int k = 0; k <= nbp; k++) begin
      @(negedge clk);
      rv[g]          = 1'b0;
      mem_req_ready  = (k == nbp);
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_id    = 8'($urandom);
      mem_resp_data  = {$urandom, $urandom};
      drive();
      #1;
      check_val("issue_valid", 64'(mem_req_valid), 64'h1);
      check_val("issue_write", 64'(mem_req_write), 64'(lw));
      check_val("issue_addr", mem_req_addr, la);
      check_val("issue_data", mem_req_data, ld);
      check_val("issue_id", 64'(mem_req_id), 64'(li));
      check_val("issue_req_ready", 64'(req_ready), 64'h0);
      check_val("issue_resp_valid", 64'(resp_valid), 64'h0);
    end

    nw = $urandom_range(0, 3);
    for (int k = 0; k <= nw; k++) begin
      logic respond;
      logic mism;
      @(negedge clk);
      respond        = (k == nw);
      mism           = ($urandom_range(0, 7) == 0);
      mem_req_ready  = 1'($urandom_range(0, 1));
      mem_resp_valid = respond && !abort;
      mem_resp_data  = {$urandom, $urandom};
      mem_resp_id    = mism ? (li ^ 8'h5A) : li;
      if (abort && respond) begin
        for (int i = 0; i < N; i++) if (!rv[i]) new_req(i);
        drive();
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("wait_reset");
        model_reset();
        drive();
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      drive();
      #1;
      check_val("wait_mem_req_valid", 64'(mem_req_valid), 64'h0);
      check_val("wait_req_ready", 64'(req_ready), 64'h0);
      check_val("wait_resp_valid", 64'(resp_valid), 64'h0);
      if (respond) begin
        exp_resp  = onehot(g);
        exp_rdata = mem_resp_data;
        if (mem_resp_id != li) exp_mis = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) begin
      rw[i] = 1'b0; ra[i] = '0; rd[i] = '0; ri[i] = '0;
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_id    = '0;
    drive();
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // All requesters held valid from reset: fetch, load, store, repeating.
    for (int t = 0; t < 6; t++) run_tx(1'b1, (t == int'(REQ_LOAD)) ? 5 : -1, 1'b0, 1'b0);
    for (int t = 0; t < 60; t++) run_tx(1'b0, (t == 0) ? 5 : -1, 1'b0, 1'b0);

    // Reset during WAIT, then a late response in IDLE; fetch must win first.
    run_tx(1'b0, 0, 1'b1, 1'b0);
    for (int t = 0; t < 3; t++) run_tx(1'b1, -1, 1'b0, (t == 0));
    for (int t = 0; t < 10; t++) run_tx(1'b0, -1, 1'b0, 1'b0);

    @(negedge clk);
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    mem_resp_valid = 1'b0;
    drive();
    #1;
    check_val("final_resp_valid", 64'(resp_valid), 64'(exp_resp));
    if (exp_resp != '0) check_val("final_resp_data", resp_data, exp_rdata);
    check_val("final_id_mismatch", 64'(id_mismatch), 64'(exp_mis));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single core-side MemoryBus between NUM_REQ requesters: fetch = 0, load = 1, store = 2.
- Round-robin grant; exactly one outstanding transaction at a time.
- Forwards the granted request to memory, waits for the tagged response, and routes it back to the originating requester.
- Sits between the FetchStage/load/store stages and the memory interface.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 64, memory_address_t width
DATA_W, 64, payload width (one 8-byte aligned word)
ID_W, 8, BusID width

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i holds a request
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  request addresses, slice i
req_data  in  NUM_REQ*DATA_W  write data, slice i
req_id  in  NUM_REQ*ID_W  BusID of requester i
req_ready  out  NUM_REQ  one-hot accept pulse
resp_valid  out  NUM_REQ  one-hot response pulse
resp_data  out  DATA_W  response payload, shared by all requesters
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts the request
mem_req_write  out  1  latched write flag
mem_req_addr  out  ADDR_W  latched address
mem_req_data  out  DATA_W  latched write data
mem_req_id  out  ID_W  latched BusID
mem_resp_valid  in  1  memory response present (read data or write ack)
mem_resp_data  in  DATA_W  response payload
mem_resp_id  in  ID_W  BusID of the response
id_mismatch  out  1  sticky error flag

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first). Reset mid-transaction drops the transaction; requesters reissue.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from last_grant+1 with wrap-around.
  - Latch write/addr/data/id from the granted slice.
  - Pulse req_ready[g] for that cycle; the requester drops or changes req_valid the next cycle.
  - Set last_grant=g; go to ISSUE.
- ISSUE: mem_req_valid=1 with latched fields, held stable until mem_req_ready=1 in the same cycle, then go to WAIT.
- WAIT:
  - On mem_resp_valid, register mem_resp_data into resp_data and pulse resp_valid[g] the next cycle.
  - If mem_resp_id differs from the latched id, set id_mismatch (cleared only by reset) but still deliver.
  - Go to IDLE.
- Latency: accept at cycle 0, mem_req_valid at cycle 1; requester response 1 cycle after mem_resp_valid. A new grant may occur in the same cycle resp_valid pulses.
- Every transaction expects exactly one response, including writes. mem_resp_valid in IDLE or ISSUE is ignored.
- Simultaneous requests: strict round-robin; a requester waits at most NUM_REQ-1 transactions.
- req_valid deasserted before grant: no effect. A granted request cannot be cancelled.

Optional Feature:
ARB_PERF_COUNTERS_EN
- Enabled:
  - Per-requester 32-bit saturating wait_cnt, incremented each cycle req_valid[i]=1 and req_ready[i]=0.
  - 32-bit busy_cnt, incremented each cycle state != IDLE.
  - Exposed as outputs wait_cnt (NUM_REQ*32) and busy_cnt (32).
  - Cleared by reset.
- Disabled: ports and counters absent.

Decomposition:
- Shared package:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT}
  - requester index constants REQ_FETCH=0, REQ_LOAD=1, REQ_STORE=2
  - reuse of memory_address_t and BusID
- Sub-module rr_picker (combinational): inputs req vector and last_grant; outputs one-hot grant and index.

Test Plan:
- Single read: fetch requests addr 0x40, id 0x11; memory answers 1 cycle after accept with data 0xDEADBEEF, id 0x11 -> req_ready[0] at c0, mem_req_valid at c1, resp_valid[0]=1 with resp_data=0xDEADBEEF the cycle after the memory response.
- Fairness: all three requesters held valid for 6 transactions from reset -> grant order 0,1,2,0,1,2.
- Backpressure: mem_req_ready held low 5 cycles -> mem_req_addr/data/id stable, no second grant, and resp delivered to the correct requester after release.
- Write: store writes 0x1234 to 0x80 -> mem_req_write=1, mem_req_data=0x1234; ack response pulses resp_valid[2] only.
- Mismatch: response id 0x22 for latched id 0x11 -> id_mismatch=1 and remains 1; resp_valid still pulses.
- Async reset asserted during WAIT -> outputs 0 immediately; after release, a late mem_resp_valid is ignored and requester 0 wins the next grant.
